// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back,
// handshakes with a wait-state memory and counts retired instructions.
module multicycle_control_unit #(
    parameter int OPCODE_W        = 6,
    parameter int CNT_W           = 32,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] instr_op,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic                illegal_op,
    output logic [3:0]          state,
    output logic [CNT_W-1:0]    retired
);

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] retired_q;
    logic             op_legal;
    logic             retire_en;

    assign op_legal = (instr_op == OP_RTYPE) || (instr_op == OP_ADDI) ||
                      (instr_op == OP_LW)    || (instr_op == OP_SW)   ||
                      (instr_op == OP_BEQ)   || (instr_op == OP_J);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: next-state defaults to the current state first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (instr_op == OP_LW || instr_op == OP_SW) state_d = S_MEM_ADDR;
                else if (instr_op == OP_RTYPE)              state_d = S_EXEC;
                else if (instr_op == OP_ADDI)               state_d = S_ADDI_EX;
                else if (instr_op == OP_BEQ)                state_d = S_BRANCH;
                else if (instr_op == OP_J)                  state_d = S_JUMP;
                else state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
            end
            S_MEM_ADDR: state_d = (instr_op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_EXEC:     state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_ADDI_WB:  state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    // Outputs are gated by rst_n so no strobe is visible while reset is held,
    // even though the reset state (FETCH) would otherwise drive mem_read.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        retire_en     = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    retire_en = !op_legal && !TRAP_ON_ILLEGAL;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retire_en  = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    retire_en = mem_ready;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    retire_en = 1'b1;
                end
                S_ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_ADDI_WB: begin
                    reg_write = 1'b1;
                    retire_en = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    retire_en     = 1'b1;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                    retire_en = 1'b1;
                end
                S_TRAP:  illegal_op = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (retire_en) begin
            retired_q <= retired_q + 1'b1;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: two instances (trap mode / 32-bit count and
// NOP mode / 4-bit count) driven with shared random instruction streams.
module tb_multicycle_control_unit;

    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011,
                           OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  instr_op;
    logic        mem_ready;

    logic        m_pcw, m_pcwc, m_iord, m_mr, m_mw, m_irw, m_m2r, m_rd, m_rw, m_asa, m_ill;
    logic [1:0]  m_asb, m_aop, m_pcs;
    logic [3:0]  m_state;
    logic [31:0] m_retired;

    logic        n_pcw, n_pcwc, n_iord, n_mr, n_mw, n_irw, n_m2r, n_rd, n_rw, n_asa, n_ill;
    logic [1:0]  n_asb, n_aop, n_pcs;
    logic [3:0]  n_state;
    logic [3:0]  n_retired;

    int          passed = 0;
    int          total  = 0;
    logic [31:0] cnt_main;
    logic [3:0]  cnt_n;

    always #5 clk = ~clk;

    multicycle_control_unit #(.OPCODE_W(6), .CNT_W(32), .TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .instr_op(instr_op), .mem_ready(mem_ready),
        .pc_write(m_pcw), .pc_write_cond(m_pcwc), .i_or_d(m_iord), .mem_read(m_mr),
        .mem_write(m_mw), .ir_write(m_irw), .mem_to_reg(m_m2r), .reg_dst(m_rd),
        .reg_write(m_rw), .alu_src_a(m_asa), .alu_src_b(m_asb), .alu_op(m_aop),
        .pc_source(m_pcs), .illegal_op(m_ill), .state(m_state), .retired(m_retired)
    );

    multicycle_control_unit #(.OPCODE_W(6), .CNT_W(4), .TRAP_ON_ILLEGAL(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .instr_op(instr_op), .mem_ready(mem_ready),
        .pc_write(n_pcw), .pc_write_cond(n_pcwc), .i_or_d(n_iord), .mem_read(n_mr),
        .mem_write(n_mw), .ir_write(n_irw), .mem_to_reg(n_m2r), .reg_dst(n_rd),
        .reg_write(n_rw), .alu_src_a(n_asa), .alu_src_b(n_asb), .alu_op(n_aop),
        .pc_source(n_pcs), .illegal_op(n_ill), .state(n_state), .retired(n_retired)
    );

    wire [16:0] m_outs = {m_pcw, m_pcwc, m_iord, m_mr, m_mw, m_irw, m_m2r, m_rd, m_rw,
                          m_asa, m_asb, m_aop, m_pcs, m_ill};
    wire [16:0] n_outs = {n_pcw, n_pcwc, n_iord, n_mr, n_mw, n_irw, n_m2r, n_rd, n_rw,
                          n_asa, n_asb, n_aop, n_pcs, n_ill};

    // Control-table view of each step: what the datapath should see in that step.
    function automatic logic [16:0] exp_out(input int st, input logic rdy);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, ill;
        logic [1:0] asb, aop, pcs;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, ill} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            12: ill = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one cycle's inputs, check both instances mid-cycle, advance past the edge.
    task automatic step(input logic [5:0] op, input logic rdy, input int em, input int en);
        instr_op  = op;
        mem_ready = rdy;
        @(negedge clk);
        check("main_state", 32'(m_state), 32'(em));
        check("main_outs", 32'(m_outs), 32'(exp_out(em, rdy)));
        check("main_retired", m_retired, cnt_main);
        check("nop_state", 32'(n_state), 32'(en));
        check("nop_outs", 32'(n_outs), 32'(exp_out(en, rdy)));
        check("nop_retired", 32'(n_retired), 32'(cnt_n));
        @(posedge clk);
        #1;
    endtask

    // Expected step sequence of one legal instruction, then one retirement.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        int st_q[$];
        logic rdy_q[$];
        for (int i = 0; i < fw; i++) begin st_q.push_back(0); rdy_q.push_back(1'b0); end
        st_q.push_back(0); rdy_q.push_back(1'b1);
        st_q.push_back(1); rdy_q.push_back(1'($urandom_range(0, 1)));
        case (op)
            OP_LW, OP_SW: begin
                st_q.push_back(2); rdy_q.push_back(1'($urandom_range(0, 1)));
                for (int i = 0; i < mw; i++) begin
                    st_q.push_back(op == OP_LW ? 3 : 5); rdy_q.push_back(1'b0);
                end
                st_q.push_back(op == OP_LW ? 3 : 5); rdy_q.push_back(1'b1);
                if (op == OP_LW) begin st_q.push_back(4); rdy_q.push_back(1'($urandom_range(0, 1))); end
            end
            OP_R:    begin st_q.push_back(6);  st_q.push_back(7); end
            OP_ADDI: begin st_q.push_back(10); st_q.push_back(11); end
            OP_BEQ:  st_q.push_back(8);
            default: st_q.push_back(9);
        endcase
        while (rdy_q.size() < st_q.size()) rdy_q.push_back(1'($urandom_range(0, 1)));
        foreach (st_q[i]) step(op, rdy_q[i], st_q[i], st_q[i]);
        cnt_main++;
        cnt_n++;
    endtask

    task automatic do_reset();
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rst_state", 32'(m_state), 32'd0);
        check("rst_outs", 32'(m_outs | n_outs), 32'd0);
        check("rst_retired", m_retired | 32'(n_retired), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cnt_main = '0;
        cnt_n = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] op;
        ops = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
        instr_op = OP_R;
        mem_ready = 1'b0;
        rst_n = 1'b0;
        cnt_main = '0;
        cnt_n = '0;
        #1;
        do_reset();

        // Directed: R-type, LW with two wait states, BEQ then J.
        run_instr(OP_R, 0, 0);
        check("r_retired_after", m_retired, 32'd1);
        run_instr(OP_LW, 0, 2);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_J, 0, 0);

        // Random legal instructions with random wait states.
        for (int k = 0; k < 60; k++)
            run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 2));

        // Illegal opcode: main instance traps, NOP instance keeps retiring.
        do op = 6'($urandom); while (op inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J});
        step(6'b111111, 1'b1, 0, 0);
        step(6'b111111, 1'($urandom_range(0, 1)), 1, 1);
        cnt_n++;
        for (int i = 0; i < 20; i++) begin
            step((i < 10) ? 6'b111111 : op, 1'b1, 12, i % 2);
            if (i % 2 == 1) cnt_n++;
        end

        // Counter wrap on the 4-bit instance.
        do_reset();
        for (int k = 0; k < 17; k++) run_instr(OP_ADDI, 0, 0);
        @(negedge clk);
        check("wrap_nop_retired", 32'(n_retired), 32'd1);
        check("wrap_main_retired", m_retired, 32'd17);
        @(posedge clk);
        #1;

        // Asynchronous reset while MEM_WR waits on memory.
        step(OP_SW, 1'b1, 0, 0);
        step(OP_SW, 1'b1, 1, 1);
        step(OP_SW, 1'b1, 2, 2);
        instr_op = OP_SW;
        mem_ready = 1'b0;
        @(negedge clk);
        check("wr_wait_mem_write", 32'(m_mw & n_mw), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_state", 32'(m_state | n_state), 32'd0);
        check("async_outs", 32'(m_outs | n_outs), 32'd0);
        check("async_retired", m_retired | 32'(n_retired), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cnt_main = '0;
        cnt_n = '0;
        @(posedge clk);
        #1;
        run_instr(OP_R, 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
